fifo_stream_reader: RTL and testbench

- Read-side consumer of the team's asynchronous FIFO, living entirely in the read clock domain.
- Drives the FIFO's rd_en from its empty flag and absorbs the FIFO's 1-cycle registered read latency in a 2-entry skid buffer.
- Presents the words as a valid/ready stream with burst framing (m_last every BURST_LEN beats) and a beat counter.
- Gives full throughput (1 word/cycle) under continuous m_ready, and loses no data under arbitrary backpressure.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_skid_buf.sv | 79 +++++++
 rtl/fifo_stream_reader.sv | 112 +++++++++++
 tb/tb_fifo_stream_reader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO and its read-side stream reader.
package fifo_pkg;

    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned OCC_WIDTH  = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } reader_state_e;

    // Bits needed to index n items; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry FIFO-ordered register buffer absorbing the FIFO's registered read latency.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [OCC_WIDTH-1:0]  occ_o
);

    logic [DATA_WIDTH-1:0] head_d, head_q;
    logic [DATA_WIDTH-1:0] tail_d, tail_q;
    logic [OCC_WIDTH-1:0]  occ_d, occ_q;
    logic                  do_pop;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        do_pop = pop_i && (occ_q != '0);

        case (occ_q)
            2'd0: begin
                if (wr_i) begin
                    head_d = wr_data_i;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (wr_i && do_pop) begin
                    head_d = wr_data_i;
                end else if (wr_i) begin
                    tail_d = wr_data_i;
                    occ_d  = 2'd2;
                end else if (do_pop) begin
                    occ_d = 2'd0;
                end
            end
            default: begin
                // Full: a write is only legal alongside a pop, which shifts tail to head.
                if (do_pop) begin
                    head_d = tail_q;
                    if (wr_i) begin
                        tail_d = wr_data_i;
                    end else begin
                        occ_d = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    always_comb begin
        head_o = head_q;
        occ_o  = occ_q;
    end

    overflow_chk : assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(wr_i && !pop_i && (occ_q == 2'd2))
    ) else $error("fifo_skid_buf: write into full buffer without pop");

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-domain consumer of the async FIFO: issues rd_en, buffers words, emits a framed stream.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  words_read,
    output logic                  busy
);

    localparam int unsigned       BEAT_W    = idx_width(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    reader_state_e         state_d, state_q;
    logic                  inflight_d, inflight_q;
    logic [BEAT_W-1:0]     beat_cnt_d, beat_cnt_q;
    logic [CNT_WIDTH-1:0]  words_d, words_q;
    logic [OCC_WIDTH-1:0]  occ;
    logic [DATA_WIDTH-1:0] head;
    logic [2:0]            level;
    logic                  valid;
    logic                  last;
    logic                  pop;
    logic                  rd_en;

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk_i     (rd_clk),
        .rst_ni    (rst_n),
        .wr_i      (inflight_q),
        .wr_data_i (fifo_data),
        .pop_i     (pop),
        .head_o    (head),
        .occ_o     (occ)
    );

    always_comb begin
        valid = (occ != '0);
        last  = valid && (beat_cnt_q == LAST_BEAT);
        pop   = valid && m_ready;
        level = 3'(occ) + 3'(inflight_q);
        // Counting in-flight words keeps the buffer from ever being asked to hold a third word.
        rd_en = (state_q == StRun) && !fifo_empty
                && ((level < 3'd2) || ((level == 3'd2) && pop));
    end

    always_comb begin
        state_d    = state_q;
        inflight_d = rd_en;
        beat_cnt_d = beat_cnt_q;
        words_d    = words_q;

        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StRun;
            end
            StRun: begin
                if (!enable) state_d = ((occ != '0) || inflight_q) ? StDrain : StIdle;
            end
            StDrain: begin
                if (enable) begin
                    state_d = StRun;
                end else if ((occ == '0) && !inflight_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (pop) begin
            beat_cnt_d = last ? '0 : beat_cnt_q + BEAT_W'(1);
            if (words_q != '1) words_d = words_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            inflight_q <= 1'b0;
            beat_cnt_q <= '0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            beat_cnt_q <= beat_cnt_d;
            words_q    <= words_d;
        end
    end

    always_comb begin
        fifo_rd_en = rd_en;
        m_valid    = valid;
        m_data     = head;
        m_last     = last;
        words_read = words_q;
        busy       = (state_q != StIdle) || (occ != '0) || inflight_q;
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: behavioural FIFO model feeding the reader, scoreboard on stream beats.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned BL = 4;

    logic          rd_clk, rst_n, enable, fifo_empty, m_ready;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_en, m_valid, m_last, busy;
    logic [DW-1:0] m_data;
    logic [15:0]   words_read;
    logic          s_rd_en, s_valid, s_last, s_busy;
    logic [DW-1:0] s_data;
    logic [3:0]    s_words;

    fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(16)) dut (
        .rd_clk(rd_clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .words_read(words_read), .busy(busy)
    );

    fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(4)) dut_sat (
        .rd_clk(rd_clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_en(s_rd_en), .m_valid(s_valid), .m_ready(m_ready),
        .m_data(s_data), .m_last(s_last), .words_read(s_words), .busy(s_busy)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] data_nxt;
    int  n_checks, n_errors;
    int  cyc, rd_cnt, first_rd, last_rd, first_valid, beats, p0;
    int  stall_left, stall_len, drop_at_rd;
    bit  stall_arm, ready_base, drop_pending;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic cycle();
        bit stalled;
        @(negedge rd_clk);
        fifo_empty = (fifo_q.size() == 0);
        stalled    = (stall_left != 0);
        m_ready    = stalled ? 1'b0 : ready_base;
        #1;
        if (drop_pending) begin
            check_eq("drain_state", dut.state_q, StDrain);
            check_eq("drain_busy", busy, 1);
            drop_pending = 0;
        end
        if (fifo_empty) check_eq("rd_en_while_empty", fifo_rd_en, 0);
        if (!m_valid) check_eq("m_last_idle", m_last, 0);
        if (stalled) begin
            check_eq("stall_valid", m_valid, 1);
            if (exp_q.size() != 0) check_eq("stall_hold", m_data, exp_q[0]);
            if (stall_left == 1) check_eq("stall_no_rd", fifo_rd_en, 0);
            stall_left--;
        end
        if (fifo_rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            if (fifo_q.size() != 0) data_nxt = fifo_q.pop_front();
            if (rd_cnt == drop_at_rd) begin
                enable       = 1'b0;
                drop_pending = 1;
                drop_at_rd   = -1;
            end
        end
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (m_valid && m_ready) begin
            check_eq("sb_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                check_eq("m_data", m_data, exp_q.pop_front());
                check_eq("m_last", m_last, (beats % BL) == BL - 1);
                check_eq("words_read", words_read, beats);
                check_eq("sat_words", s_words, (beats > 15) ? 15 : beats);
            end
            beats++;
            if (stall_arm) begin
                stall_left = stall_len;
                stall_arm  = 0;
            end
        end
        @(posedge rd_clk);
        #1;
        fifo_data = data_nxt;
        cyc++;
    endtask

    task automatic run_until_drained(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            cycle();
            n++;
        end
        check_eq("drain_done", exp_q.size() == 0, 1);
    endtask

    task automatic clear_counts();
        rd_cnt = 0; first_rd = -1; last_rd = -1; first_valid = -1;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0; beats = 0;
        stall_left = 0; stall_len = 0; stall_arm = 0; drop_at_rd = -1; drop_pending = 0;
        rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1;
        fifo_data = '0; data_nxt = '0; ready_base = 1'b0;
        clear_counts();
        repeat (2) @(negedge rd_clk);
        #1;
        check_eq("rst_valid", m_valid, 0);
        check_eq("rst_data", m_data, 0);
        check_eq("rst_last", m_last, 0);
        check_eq("rst_words", words_read, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rd_en", fifo_rd_en, 0);
        rst_n = 1'b1;

        // Fill the buffer to two words under full backpressure, then reset mid-stream.
        enable = 1'b1;
        push(32'h11); push(32'h22); push(32'h33);
        repeat (6) cycle();
        check_eq("pre_reset_valid", m_valid, 1);
        check_eq("pre_reset_rd_cnt", rd_cnt, 2);
        @(negedge rd_clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", m_valid, 0);
        check_eq("midrst_data", m_data, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_rd_en", fifo_rd_en, 0);
        fifo_q.delete(); exp_q.delete(); beats = 0; enable = 1'b0;
        @(negedge rd_clk);
        rst_n = 1'b1;
        clear_counts();
        push(32'h55);
        repeat (3) cycle();
        check_eq("disabled_no_rd", rd_cnt, 0);
        check_eq("disabled_busy", busy, 0);
        fifo_q.delete(); exp_q.delete();

        // Continuous streaming.
        clear_counts();
        ready_base = 1'b1; enable = 1'b1;
        for (int i = 0; i < 8; i++) push(32'hA0 + i);
        run_until_drained(40);
        check_eq("stream_rd_cnt", rd_cnt, 8);
        check_eq("stream_rd_span", last_rd - first_rd + 1, 8);
        check_eq("stream_latency", first_valid - first_rd, 2);
        check_eq("stream_words", words_read, 8);
        check_eq("stream_sat_words", s_words, 8);

        // Backpressure after the first beat.
        clear_counts();
        stall_len = 5; stall_arm = 1;
        for (int i = 0; i < 8; i++) push(32'hB0 + i);
        run_until_drained(60);
        check_eq("bp_rd_cnt", rd_cnt, 8);

        // Empty FIFO stall.
        repeat (2) cycle();
        clear_counts();
        p0 = beats;
        push(32'hD0);
        repeat (6) cycle();
        check_eq("stall_one_rd", rd_cnt, 1);
        check_eq("stall_one_beat", beats - p0, 1);
        repeat (10) cycle();
        check_eq("stall_no_more_rd", rd_cnt, 1);
        push(32'hD1);
        run_until_drained(20);
        check_eq("stall_resume_rd", rd_cnt, 2);
        check_eq("stall_resume_beats", beats - p0, 2);

        // Enable drop on the cycle of a read issue.
        repeat (2) cycle();
        clear_counts();
        p0 = beats;
        drop_at_rd = 2;
        for (int i = 0; i < 6; i++) push(32'hC0 + i);
        begin
            int n = 0;
            do begin
                cycle();
                n++;
            end while ((busy || drop_pending) && n < 30);
        end
        check_eq("drop_idle_busy", busy, 0);
        check_eq("drop_idle_state", dut.state_q, StIdle);
        check_eq("drop_beats", beats - p0, 2);
        check_eq("drop_rd_cnt", rd_cnt, 2);
        check_eq("drop_fifo_left", fifo_q.size(), 4);
        enable = 1'b1;
        run_until_drained(30);
        check_eq("resume_beats", beats - p0, 6);

        repeat (2) cycle();
        check_eq("final_words", words_read, beats);
        check_eq("final_sat_words", s_words, 15);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
